// File: rtl/demux4_stream.sv
// 1:4 stream demultiplexer: one valid/ready input routed by in_sel into four
// independent 2-entry FIFOs, each with a saturating accepted-word counter.
module demux4_stream #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [1:0]          in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [4*DATA_W-1:0] out_data,
  output logic [3:0]          out_valid,
  input  logic [3:0]          out_ready,
  output logic [4*CNT_W-1:0]  cnt
);

  logic [1:0]        occ_q  [4];
  logic [1:0]        occ_d  [4];
  logic [DATA_W-1:0] head_q [4];
  logic [DATA_W-1:0] head_d [4];
  logic [DATA_W-1:0] tail_q [4];
  logic [DATA_W-1:0] tail_d [4];
  logic [CNT_W-1:0]  cnt_q  [4];
  logic [CNT_W-1:0]  cnt_d  [4];
  logic [3:0]        out_valid_q;
  logic [3:0]        out_valid_d;
  logic [3:0]        full_s;
  logic [3:0]        push_s;
  logic [3:0]        pop_s;

  // in_valid gates every push, so an unknown in_sel/in_ready while idle never reaches state
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      full_s[k] = (occ_q[k] == 2'd2);
    end
    in_ready = !rst && !full_s[in_sel];
    for (int k = 0; k < 4; k++) begin
      push_s[k] = in_valid && in_ready && (in_sel == 2'(k));
      pop_s[k]  = out_valid_q[k] && out_ready[k];
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      occ_d[k]  = occ_q[k];
      head_d[k] = head_q[k];
      tail_d[k] = tail_q[k];
      cnt_d[k]  = cnt_q[k];
      case ({push_s[k], pop_s[k]})
        2'b10: begin
          if (occ_q[k] == 2'd0) begin
            head_d[k] = in_data;
          end else begin
            tail_d[k] = in_data;
          end
          occ_d[k] = occ_q[k] + 2'd1;
        end
        2'b01: begin
          head_d[k] = tail_q[k];
          occ_d[k]  = occ_q[k] - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; with one entry the new word replaces the head
          if (occ_q[k] == 2'd1) begin
            head_d[k] = in_data;
          end else begin
            head_d[k] = tail_q[k];
            tail_d[k] = in_data;
          end
        end
        default: begin
          occ_d[k] = occ_q[k];
        end
      endcase
      if (push_s[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
        cnt_d[k] = cnt_q[k] + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_d[k] = cnt_q[k];
      end
      out_valid_d[k] = (occ_d[k] != 2'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        occ_q[k]  <= 2'd0;
        head_q[k] <= {DATA_W{1'b0}};
        tail_q[k] <= {DATA_W{1'b0}};
        cnt_q[k]  <= {CNT_W{1'b0}};
      end
      out_valid_q <= 4'b0000;
    end else begin
      for (int k = 0; k < 4; k++) begin
        occ_q[k]  <= occ_d[k];
        head_q[k] <= head_d[k];
        tail_q[k] <= tail_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      out_data[k*DATA_W +: DATA_W] = head_q[k];
      cnt[k*CNT_W +: CNT_W]        = cnt_q[k];
    end
    out_valid = out_valid_q;
  end

endmodule
